// File: rtl/appliance_hub_pkg.sv
// Shared constants and types for the appliance hub: register indices and command FSM states.
package appliance_hub_pkg;

  localparam logic [1:0] REG_SP    = 2'd0;
  localparam logic [1:0] REG_MODE  = 2'd1;
  localparam logic [1:0] REG_LEVEL = 2'd2;
  localparam logic [1:0] REG_TIMER = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/hub_slot.sv
// One device slot: setpoint/mode/level/timer registers with setpoint clamp and auto-off countdown.
module hub_slot
  import appliance_hub_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int SP_MIN = 16,
  parameter int SP_MAX = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             tick,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] mode,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] timer,
  output logic             expired
);

  localparam logic [WIDTH-1:0] SP_LO = WIDTH'(SP_MIN);
  localparam logic [WIDTH-1:0] SP_HI = WIDTH'(SP_MAX);

  function automatic logic [WIDTH-1:0] clamp_sp(input logic [WIDTH-1:0] d);
    if (d < SP_LO) return SP_LO;
    if (d > SP_HI) return SP_HI;
    return d;
  endfunction

  // A mode or timer write in the same cycle as a tick overrides the countdown.
  logic timer_wr;
  assign timer_wr = wr_en && (wr_reg == REG_MODE || wr_reg == REG_TIMER);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      mode    <= '0;
      level   <= '0;
      timer   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (wr_en) begin
        case (wr_reg)
          REG_SP:    sp <= clamp_sp(wr_data);
          REG_MODE: begin
            mode <= wr_data;
            if (wr_data == '0) timer <= '0;
          end
          REG_LEVEL: level <= wr_data;
          REG_TIMER: timer <= wr_data;
        endcase
      end
      if (tick && !timer_wr && timer != '0) begin
        timer <= timer - WIDTH'(1);
        if (timer == WIDTH'(1)) begin
          mode    <= '0;
          expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/appliance_hub.sv
// Appliance hub top: command FSM, shared timer prescaler, N_DEV slot banks and registered read port.
module appliance_hub
  import appliance_hub_pkg::*;
#(
  parameter int N_DEV    = 4,
  parameter int WIDTH    = 5,
  parameter int SP_MIN   = 16,
  parameter int SP_MAX   = 30,
  parameter int TICK_DIV = 1000,
  localparam int DW      = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DW-1:0]    cmd_dev,
  input  logic [1:0]       cmd_reg,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [DW-1:0]    rd_dev,
  input  logic [1:0]       rd_reg,
  output logic [WIDTH-1:0] rd_data,
  output logic [N_DEV-1:0] dev_on,
  output logic [N_DEV-1:0] expired,
  output logic             cmd_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW:0]   N_DEV_W  = (DW + 1)'(N_DEV);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= tick ? '0 : presc + PW'(1);
  end

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = APPLY;
      end
      APPLY: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: command captured on acceptance, committed during APPLY
  logic [DW-1:0]    cmd_dev_p0;
  logic [1:0]       cmd_reg_p0;
  logic [WIDTH-1:0] cmd_data_p0;
  logic             apply;

  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      cmd_dev_p0  <= cmd_dev;
      cmd_reg_p0  <= cmd_reg;
      cmd_data_p0 <= cmd_data;
    end
  end

  assign apply   = (state == APPLY);
  assign cmd_err = apply && ({1'b0, cmd_dev_p0} >= N_DEV_W);

  logic [WIDTH-1:0] sp_a    [N_DEV];
  logic [WIDTH-1:0] mode_a  [N_DEV];
  logic [WIDTH-1:0] level_a [N_DEV];
  logic [WIDTH-1:0] timer_a [N_DEV];
  logic [N_DEV-1:0] wr_en;

  for (genvar i = 0; i < N_DEV; i++) begin : g_slot
    assign wr_en[i]  = apply && (cmd_dev_p0 == DW'(i));
    assign dev_on[i] = (mode_a[i] != '0);

    hub_slot #(
      .WIDTH  (WIDTH),
      .SP_MIN (SP_MIN),
      .SP_MAX (SP_MAX)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_reg  (cmd_reg_p0),
      .wr_data (cmd_data_p0),
      .tick    (tick),
      .sp      (sp_a[i]),
      .mode    (mode_a[i]),
      .level   (level_a[i]),
      .timer   (timer_a[i]),
      .expired (expired[i])
    );
  end

  // ---- stage p1: registered read; unmatched slot selects fall through to 0
  logic [WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (rd_dev == DW'(i)) begin
        case (rd_reg)
          REG_SP:    rd_mux = sp_a[i];
          REG_MODE:  rd_mux = mode_a[i];
          REG_LEVEL: rd_mux = level_a[i];
          REG_TIMER: rd_mux = timer_a[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_appliance_hub.sv
// Self-checking bench for appliance_hub: scoreboarded register reads plus per-feature scenario tasks.
module tb_appliance_hub;

  localparam int N_DEV    = 3;
  localparam int WIDTH    = 6;
  localparam int SP_MIN   = 16;
  localparam int SP_MAX   = 30;
  localparam int TICK_DIV = 4;
  localparam int DW       = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DW-1:0]    cmd_dev;
  logic [1:0]       cmd_reg;
  logic [WIDTH-1:0] cmd_data;
  logic [DW-1:0]    rd_dev;
  logic [1:0]       rd_reg;
  logic [WIDTH-1:0] rd_data;
  logic [N_DEV-1:0] dev_on;
  logic [N_DEV-1:0] expired;
  logic             cmd_err;

  appliance_hub #(
    .N_DEV    (N_DEV),
    .WIDTH    (WIDTH),
    .SP_MIN   (SP_MIN),
    .SP_MAX   (SP_MAX),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dev   (cmd_dev),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .rd_dev    (rd_dev),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .dev_on    (dev_on),
    .expired   (expired),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: value equals the hub's count during the current cycle.
  int pc;
  always @(posedge clk) begin
    if (rst) pc <= 0;
    else     pc <= (pc == TICK_DIV - 1) ? 0 : pc + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int m [N_DEV][4];
  int exp_q [$];

  function automatic int clamp_m(input int d);
    if (d < SP_MIN) return SP_MIN;
    if (d > SP_MAX) return SP_MAX;
    return d;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < N_DEV; i++)
      for (int j = 0; j < 4; j++) m[i][j] = 0;
  endtask

  task automatic model_write(input int dev, input int r, input int d);
    if (dev < N_DEV) begin
      case (r)
        0: m[dev][0] = clamp_m(d);
        1: begin m[dev][1] = d; if (d == 0) m[dev][3] = 0; end
        2: m[dev][2] = d;
        default: m[dev][3] = d;
      endcase
    end
  endtask

  task automatic send_cmd(input int dev, input int r, input int d);
    int w;
    w = 0;
    while (!cmd_ready && w < 10) begin step; w++; end
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_dev   = DW'(dev);
    cmd_reg   = 2'(r);
    cmd_data  = WIDTH'(d);
    step;
    cmd_valid = 1'b0;
    step;
    model_write(dev, r, d);
  endtask

  task automatic do_read(input int dev, input int r, input int e);
    logic [WIDTH-1:0] got, want;
    exp_q.push_back(e);
    rd_dev = DW'(dev);
    rd_reg = 2'(r);
    step;
    got  = rd_data;
    want = WIDTH'(exp_q.pop_front());
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL read_dev%0d_reg%0d: got %0d required %0d", dev, r, got, want);
    end
  endtask

  task automatic wait_pc(input int v);
    int w;
    w = 0;
    while (pc != v && w < 10) begin step; w++; end
    n_chk++;
    if (pc != v) begin
      n_fail++;
      $display("FAIL wait_phase: phase %0d required %0d", pc, v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_data = '0;
    rd_dev = '0; rd_reg = '0;
    step; step;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    n_chk++; if (dev_on !== '0) begin n_fail++; $display("FAIL reset_dev_on: got %b required 0", dev_on); end
    n_chk++; if (expired !== '0) begin n_fail++; $display("FAIL reset_expired: got %b required 0", expired); end
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b required 0", cmd_err); end
    n_chk++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0d required 0", rd_data); end
    rst = 1'b0;
    model_clear();
    do_read(2, 0, 0);
    do_read(1, 3, 0);
  endtask

  task automatic test_setpoint_clamp;
    send_cmd(2, 0, 40);
    do_read(2, 0, 30);
    send_cmd(2, 0, 3);
    do_read(2, 0, 16);
    send_cmd(2, 0, 22);
    do_read(2, 0, 22);
  endtask

  task automatic test_back_to_back;
    int dv [3] = '{2, 2, 2};
    int rg [3] = '{2, 0, 2};
    int dt [3] = '{5, 20, 9};
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1;
      cmd_dev   = DW'(dv[k]);
      cmd_reg   = 2'(rg[k]);
      cmd_data  = WIDTH'(dt[k]);
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle%0d: got %b required 1", k, cmd_ready); end
      step;
      n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_apply%0d: got %b required 0", k, cmd_ready); end
      if (k == 2) cmd_valid = 1'b0;
      step;
      model_write(dv[k], rg[k], dt[k]);
    end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_end: got %b required 1", cmd_ready); end
    do_read(2, 2, 9);
    do_read(2, 0, 20);
  endtask

  task automatic test_timer_expiry;
    int ticks;
    bit is_tick;
    send_cmd(1, 1, 1);
    send_cmd(1, 3, 2);
    ticks = 0;
    for (int c = 0; c < 20 && ticks < 2; c++) begin
      is_tick = (pc == TICK_DIV - 1);
      n_chk++;
      if (dev_on[1] !== 1'b1 || expired[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL expiry_armed: dev_on=%b expired=%b required 1/0", dev_on[1], expired[1]);
      end
      step;
      if (is_tick) ticks++;
    end
    n_chk++; if (dev_on[1] !== 1'b0) begin n_fail++; $display("FAIL expiry_dev_off: got %b required 0", dev_on[1]); end
    n_chk++; if (expired[1] !== 1'b1) begin n_fail++; $display("FAIL expiry_pulse: got %b required 1", expired[1]); end
    step;
    n_chk++; if (expired !== '0) begin n_fail++; $display("FAIL expiry_pulse_end: got %b required 0", expired); end
    model_write(1, 1, 0);
    do_read(1, 1, 0);
    do_read(1, 3, 0);
  endtask

  task automatic test_tick_collision;
    send_cmd(0, 1, 1);
    wait_pc(2);
    send_cmd(0, 3, 1);
    wait_pc(2);
    send_cmd(0, 3, 5);
    n_chk++; if (expired[0] !== 1'b0) begin n_fail++; $display("FAIL collide_no_expiry: got %b required 0", expired[0]); end
    n_chk++; if (dev_on[0] !== 1'b1) begin n_fail++; $display("FAIL collide_dev_on: got %b required 1", dev_on[0]); end
    do_read(0, 3, 5);
    do_read(0, 1, 1);
    send_cmd(0, 1, 0);
    do_read(0, 3, 0);
  endtask

  task automatic test_bad_dev;
    cmd_valid = 1'b1; cmd_dev = DW'(3); cmd_reg = 2'(2); cmd_data = WIDTH'(13);
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b required 0", cmd_err); end
    step;
    cmd_valid = 1'b0;
    n_chk++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b required 1", cmd_err); end
    step;
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_end: got %b required 0", cmd_err); end
    for (int i = 0; i < N_DEV; i++) begin
      do_read(i, 0, m[i][0]);
      do_read(i, 2, m[i][2]);
    end
    do_read(3, 0, 0);
    do_read(3, 2, 0);
  endtask

  task automatic test_reset_mid_apply;
    int bad;
    send_cmd(0, 1, 1);
    send_cmd(0, 3, 3);
    cmd_valid = 1'b1; cmd_dev = '0; cmd_reg = 2'(2); cmd_data = WIDTH'(7);
    step;
    cmd_valid = 1'b0;
    rst = 1'b1;
    step;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", cmd_ready); end
    n_chk++; if (dev_on !== '0) begin n_fail++; $display("FAIL rstmid_dev_on: got %b required 0", dev_on); end
    n_chk++; if (expired !== '0) begin n_fail++; $display("FAIL rstmid_expired: got %b required 0", expired); end
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_err: got %b required 0", cmd_err); end
    n_chk++; if (rd_data !== '0) begin n_fail++; $display("FAIL rstmid_rd_data: got %0d required 0", rd_data); end
    rst = 1'b0;
    model_clear();
    do_read(0, 2, 0);
    do_read(0, 1, 0);
    do_read(0, 3, 0);
    do_read(2, 0, 0);
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (expired !== '0 || dev_on !== '0) bad++;
      step;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_no_expiry: %0d bad cycles required 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_setpoint_clamp();
    test_back_to_back();
    test_timer_expiry();
    test_tick_collision();
    test_bad_dev();
    test_reset_mid_apply();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
